// File: rtl/pong_engine_if.sv
// rtl/pong_engine_if.sv - player controls and game-state outputs of the pong engine
interface pong_engine_if;
  logic       player_1_a;
  logic       player_1_b;
  logic       player_1_switch;
  logic       player_2_a;
  logic       player_2_b;
  logic       player_2_switch;
  logic [9:0] o_pad1_y;
  logic [9:0] o_pad2_y;
  logic [9:0] o_ball_x;
  logic [9:0] o_ball_y;
  logic [3:0] o_score1;
  logic [3:0] o_score2;
  logic [1:0] o_state;

  modport slave (
    input  player_1_a, player_1_b, player_1_switch,
    input  player_2_a, player_2_b, player_2_switch,
    output o_pad1_y, o_pad2_y, o_ball_x, o_ball_y,
    output o_score1, o_score2, o_state
  );

  modport master (
    output player_1_a, player_1_b, player_1_switch,
    output player_2_a, player_2_b, player_2_switch,
    input  o_pad1_y, o_pad2_y, o_ball_x, o_ball_y,
    input  o_score1, o_score2, o_state
  );
endinterface

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - pong game logic: encoder paddles, ball physics, scoring, frame-ticked FSM
module pong_engine #(
  parameter int HRES         = 640,
  parameter int VRES         = 480,
  parameter int PAD_H        = 64,
  parameter int PAD_W        = 8,
  parameter int BALL         = 8,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int PAD_STEP     = 4,
  parameter int BALL_V       = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic         CLOCK_25,
  input  logic         rst_n,
  input  logic         i_vblank,
  pong_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  localparam logic [9:0] CX       = 10'((HRES - BALL) / 2);
  localparam logic [9:0] CY       = 10'((VRES - BALL) / 2);
  localparam logic [9:0] PAD_MAX  = 10'(VRES - PAD_H);
  localparam logic [9:0] PAD_MID  = 10'((VRES - PAD_H) / 2);
  localparam logic [9:0] STEP     = 10'(PAD_STEP);
  localparam logic [9:0] Y_MAX    = 10'(VRES - BALL);
  localparam logic [9:0] P1_HIT_X = 10'(P1_X + PAD_W);
  localparam logic [9:0] P2_HIT_X = 10'(P2_X - BALL);

  localparam logic signed [10:0] S_ZERO = 11'sd0;
  localparam logic signed [10:0] S_V    = 11'(BALL_V);
  localparam logic signed [10:0] S_BALL = 11'(BALL);
  localparam logic signed [10:0] S_P1X  = 11'(P1_X);
  localparam logic signed [10:0] S_P1R  = 11'(P1_X + PAD_W);
  localparam logic signed [10:0] S_P2X  = 11'(P2_X);
  localparam logic signed [10:0] S_P2R  = 11'(P2_X + PAD_W);
  localparam logic signed [10:0] S_XMAX = 11'(HRES - BALL);
  localparam logic signed [10:0] S_YMAX = 11'(VRES - BALL);
  localparam logic [10:0] U_BALL = 11'(BALL);
  localparam logic [10:0] U_PADH = 11'(PAD_H);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

  state_t state, state_next;

  logic [6:0] raw, sync1, sync2;
  logic       vb_prev;
  logic [1:0] sw_prev, ab1_prev, ab2_prev;
  logic       vb_s, sw1, sw2, tick, press_any, start, start_pend;
  logic [1:0] ab1, ab2;

  logic [9:0]    pad1, pad2, pad1_out, pad2_out;
  logic [9:0]    ball_x, ball_y;
  logic          dx, dy;
  logic [3:0]    score1, score2;
  logic [CW-1:0] serve_cnt;

  logic signed [10:0] xs, ys, nx, ny;
  logic [9:0] y_next;
  logic       dy_next, ov1, ov2, hit_l, hit_r, miss_l, miss_r, point1, point2;
  logic [3:0] sc1_next, sc2_next;

  logic ctr_clr, ctr_inc, ball_centre, ball_step, score_clr;

  assign raw = {i_vblank, bus.player_1_a, bus.player_1_b, bus.player_1_switch,
                bus.player_2_a, bus.player_2_b, bus.player_2_switch};

  assign vb_s      = sync2[6];
  assign ab1       = sync2[5:4];
  assign sw1       = sync2[3];
  assign ab2       = sync2[2:1];
  assign sw2       = sync2[0];
  assign tick      = vb_s & ~vb_prev;
  assign press_any = (sw1 & ~sw_prev[1]) | (sw2 & ~sw_prev[0]);
  assign start     = press_any | start_pend;

  // Returns {valid, down}; Gray index {a, a^b} makes a +1 step mean "down".
  function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] delta;
    delta = {cur[1], cur[1] ^ cur[0]} - {prev[1], prev[1] ^ prev[0]};
    case (delta)
      2'd1:    quad_step = 2'b11;
      2'd3:    quad_step = 2'b10;
      default: quad_step = 2'b00;
    endcase
  endfunction

  function automatic logic [9:0] pad_move(input logic [9:0] pos, input logic [1:0] stp);
    logic [9:0] r;
    r = pos;
    if (stp[1]) begin
      if (stp[0]) r = (pos >= PAD_MAX - STEP) ? PAD_MAX : pos + STEP;
      else        r = (pos <= STEP) ? 10'd0 : pos - STEP;
    end
    return r;
  endfunction

  always_comb begin
    xs      = signed'({1'b0, ball_x});
    ys      = signed'({1'b0, ball_y});
    nx      = dx ? xs + S_V : xs - S_V;
    ny      = dy ? ys + S_V : ys - S_V;
    y_next  = ny[9:0];
    dy_next = dy;
    if (ny <= S_ZERO) begin
      y_next  = '0;
      dy_next = 1'b1;
    end else if (ny >= S_YMAX) begin
      y_next  = Y_MAX;
      dy_next = 1'b0;
    end
    // Overlap tests the live paddle so a last-moment move still counts.
    ov1    = ({1'b0, ball_y} + U_BALL > {1'b0, pad1}) && ({1'b0, ball_y} < {1'b0, pad1} + U_PADH);
    ov2    = ({1'b0, ball_y} + U_BALL > {1'b0, pad2}) && ({1'b0, ball_y} < {1'b0, pad2} + U_PADH);
    hit_l  = !dx && (nx <= S_P1R) && (nx + S_BALL > S_P1X) && ov1;
    hit_r  = dx && (nx + S_BALL >= S_P2X) && (nx < S_P2R) && ov2;
    miss_l = nx <= S_ZERO;
    miss_r = nx >= S_XMAX;
    point1 = miss_r && !hit_l && !hit_r;
    point2 = miss_l && !hit_l && !hit_r;
    sc1_next = (score1 >= WIN) ? WIN : score1 + 4'd1;
    sc2_next = (score2 >= WIN) ? WIN : score2 + 4'd1;
  end

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (tick && start) state_next = SERVE;
      SERVE: if (tick && serve_cnt == SERVE_LAST) state_next = PLAY;
      PLAY: begin
        if (tick && point1)      state_next = (sc1_next == WIN) ? OVER : SERVE;
        else if (tick && point2) state_next = (sc2_next == WIN) ? OVER : SERVE;
      end
      OVER:  if (tick && start) state_next = SERVE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
    ball_centre = 1'b0;
    ball_step   = 1'b0;
    score_clr   = 1'b0;
    case (state)
      IDLE: begin
        ctr_clr     = tick && start;
        ball_centre = tick && start;
      end
      SERVE: begin
        ctr_clr = tick && (serve_cnt == SERVE_LAST);
        ctr_inc = tick && (serve_cnt != SERVE_LAST);
      end
      PLAY: begin
        ball_step = tick;
        ctr_clr   = tick && (point1 || point2);
      end
      OVER: begin
        ctr_clr     = tick && start;
        ball_centre = tick && start;
        score_clr   = tick && start;
      end
      default: ctr_clr = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      vb_prev    <= 1'b0;
      sw_prev    <= '0;
      ab1_prev   <= '0;
      ab2_prev   <= '0;
      start_pend <= 1'b0;
      pad1       <= PAD_MID;
      pad2       <= PAD_MID;
      pad1_out   <= PAD_MID;
      pad2_out   <= PAD_MID;
      ball_x     <= CX;
      ball_y     <= CY;
      dx         <= 1'b1;
      dy         <= 1'b1;
      score1     <= '0;
      score2     <= '0;
      serve_cnt  <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      vb_prev  <= vb_s;
      sw_prev  <= {sw1, sw2};
      ab1_prev <= ab1;
      ab2_prev <= ab2;
      pad1     <= pad_move(pad1, quad_step(ab1_prev, ab1));
      pad2     <= pad_move(pad2, quad_step(ab2_prev, ab2));

      // A press between frames is held until the next tick can act on it.
      if (tick)
        start_pend <= 1'b0;
      else if (press_any && (state == IDLE || state == OVER))
        start_pend <= 1'b1;

      if (tick) begin
        pad1_out <= pad1;
        pad2_out <= pad2;
      end

      if (ctr_clr)      serve_cnt <= '0;
      else if (ctr_inc) serve_cnt <= serve_cnt + 1'b1;

      if (ball_centre) begin
        ball_x <= CX;
        ball_y <= CY;
      end
      if (score_clr) begin
        score1 <= '0;
        score2 <= '0;
        dx     <= 1'b1;
      end

      if (ball_step) begin
        ball_y <= y_next;
        dy     <= dy_next;
        if (hit_l) begin
          ball_x <= P1_HIT_X;
          dx     <= 1'b1;
        end else if (hit_r) begin
          ball_x <= P2_HIT_X;
          dx     <= 1'b0;
        end else if (miss_l) begin
          score2 <= sc2_next;
          ball_x <= CX;
          ball_y <= CY;
          dx     <= 1'b0;
        end else if (miss_r) begin
          score1 <= sc1_next;
          ball_x <= CX;
          ball_y <= CY;
          dx     <= 1'b1;
        end else begin
          ball_x <= nx[9:0];
        end
      end
    end
  end

  assign bus.o_pad1_y = pad1_out;
  assign bus.o_pad2_y = pad2_out;
  assign bus.o_ball_x = ball_x;
  assign bus.o_ball_y = ball_y;
  assign bus.o_score1 = score1;
  assign bus.o_score2 = score2;
  assign bus.o_state  = state;
endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - directed vector bench for pong_engine
module tb_pong_engine;
  logic clk = 1'b0;
  logic rst_n;
  logic vblank;
  logic [1:0] enc1, enc2;
  int n_cmp = 0;
  int n_bad = 0;

  always #20 clk = ~clk;

  pong_engine_if bus ();

  pong_engine dut (
    .CLOCK_25(clk),
    .rst_n   (rst_n),
    .i_vblank(vblank),
    .bus     (bus)
  );

  typedef struct {
    int p1_steps;
    int p2_steps;
    bit press1;
    int ticks;
    int st;
    int bx;
    int by;
    int s1;
    int s2;
    int pad1;
    int pad2;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input int st, input int bx, input int by,
                           input int s1, input int s2, input int p1, input int p2);
    check("state",  idx, int'(bus.o_state),  st);
    check("ball_x", idx, int'(bus.o_ball_x), bx);
    check("ball_y", idx, int'(bus.o_ball_y), by);
    check("score1", idx, int'(bus.o_score1), s1);
    check("score2", idx, int'(bus.o_score2), s2);
    check("pad1_y", idx, int'(bus.o_pad1_y), p1);
    check("pad2_y", idx, int'(bus.o_pad2_y), p2);
  endtask

  task automatic frame();
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic drive_enc(input int pl, input logic [1:0] v);
    if (pl == 1) begin
      {bus.player_1_a, bus.player_1_b} = v;
      enc1 = v;
    end else begin
      {bus.player_2_a, bus.player_2_b} = v;
      enc2 = v;
    end
    repeat (4) @(negedge clk);
  endtask

  // Positive n steps down (00->01->11->10), negative n steps up.
  task automatic step_enc(input int pl, input int n);
    logic [1:0] cur, nxt;
    int cnt;
    cnt = (n < 0) ? -n : n;
    for (int k = 0; k < cnt; k++) begin
      cur = (pl == 1) ? enc1 : enc2;
      if (n > 0)
        case (cur)
          2'b00: nxt = 2'b01;
          2'b01: nxt = 2'b11;
          2'b11: nxt = 2'b10;
          default: nxt = 2'b00;
        endcase
      else
        case (cur)
          2'b00: nxt = 2'b10;
          2'b10: nxt = 2'b11;
          2'b11: nxt = 2'b01;
          default: nxt = 2'b00;
        endcase
      drive_enc(pl, nxt);
    end
  endtask

  task automatic press(input int pl);
    if (pl == 1) bus.player_1_switch = 1'b1;
    else         bus.player_2_switch = 1'b1;
    repeat (4) @(negedge clk);
    bus.player_1_switch = 1'b0;
    bus.player_2_switch = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{0,   0,   1'b0, 5,   0, 316, 236, 0, 0, 208, 208};
    vecs[1]  = '{0,   60,  1'b0, 0,   0, 316, 236, 0, 0, 208, 208};
    vecs[2]  = '{0,   0,   1'b0, 1,   0, 316, 236, 0, 0, 208, 416};
    vecs[3]  = '{0,   0,   1'b1, 1,   1, 316, 236, 0, 0, 208, 416};
    vecs[4]  = '{0,   0,   1'b0, 59,  1, 316, 236, 0, 0, 208, 416};
    vecs[5]  = '{0,   0,   1'b0, 1,   2, 316, 236, 0, 0, 208, 416};
    vecs[6]  = '{0,   0,   1'b0, 1,   2, 318, 238, 0, 0, 208, 416};
    vecs[7]  = '{0,   0,   1'b0, 144, 2, 606, 418, 0, 0, 208, 416};
    vecs[8]  = '{-12, 0,   1'b0, 1,   2, 608, 416, 0, 0, 160, 416};
    vecs[9]  = '{0,   0,   1'b0, 291, 2, 26,  166, 0, 0, 160, 416};
    vecs[10] = '{0,   0,   1'b0, 1,   2, 24,  168, 0, 0, 160, 416};
    vecs[11] = '{-40, -54, 1'b0, 291, 2, 606, 194, 0, 0, 0,   200};
    vecs[12] = '{0,   0,   1'b0, 1,   2, 608, 192, 0, 0, 0,   200};
    vecs[13] = '{0,   0,   1'b0, 303, 2, 2,   414, 0, 0, 0,   200};
    vecs[14] = '{0,   0,   1'b0, 1,   1, 316, 236, 0, 1, 0,   200};
    vecs[15] = '{0,   0,   1'b0, 60,  2, 316, 236, 0, 1, 0,   200};
    vecs[16] = '{0,   0,   1'b0, 1,   2, 314, 238, 0, 1, 0,   200};

    rst_n  = 1'b0;
    vblank = 1'b0;
    enc1   = 2'b00;
    enc2   = 2'b00;
    bus.player_1_a = 1'b0;
    bus.player_1_b = 1'b0;
    bus.player_2_a = 1'b0;
    bus.player_2_b = 1'b0;
    bus.player_1_switch = 1'b0;
    bus.player_2_switch = 1'b0;
    repeat (3) @(negedge clk);
    check_all(100, 0, 316, 236, 0, 0, 208, 208);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      step_enc(1, vecs[i].p1_steps);
      step_enc(2, vecs[i].p2_steps);
      if (vecs[i].press1) press(1);
      frames(vecs[i].ticks);
      check_all(i, vecs[i].st, vecs[i].bx, vecs[i].by, vecs[i].s1, vecs[i].s2,
                vecs[i].pad1, vecs[i].pad2);
    end

    // Asynchronous reset in the middle of PLAY.
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1 check_all(200, 0, 316, 236, 0, 0, 208, 208);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame();
    check_all(201, 0, 316, 236, 0, 0, 208, 208);

    // Both encoder bits flipping together must not move the paddle.
    drive_enc(1, 2'b11);
    frame();
    check("dbl_pad1", 0, int'(bus.o_pad1_y), 208);
    drive_enc(1, 2'b00);
    frame();
    check("dbl_pad1", 1, int'(bus.o_pad1_y), 208);
    step_enc(1, 1);
    frame();
    check("step_pad1", 0, int'(bus.o_pad1_y), 212);

    // Nine right-side misses take player 1 from 0 to the winning score.
    press(2);
    frame();
    check("start_state", 0, int'(bus.o_state), 1);
    for (int r = 1; r <= 9; r++) begin
      frames(60);
      check("serve_done", r, int'(bus.o_state), 2);
      frames(158);
      check("round_score1", r, int'(bus.o_score1), r);
      check("round_score2", r, int'(bus.o_score2), 0);
      check("round_state", r, int'(bus.o_state), (r == 9) ? 3 : 1);
      check("round_ball_x", r, int'(bus.o_ball_x), 316);
    end
    frames(2);
    check("over_hold_state", 0, int'(bus.o_state), 3);
    check("over_hold_score1", 0, int'(bus.o_score1), 9);

    press(2);
    frame();
    check_all(300, 1, 316, 236, 0, 0, 212, 208);
    frames(60);
    check("reserve_state", 0, int'(bus.o_state), 2);
    frame();
    check("reserve_ball_x", 0, int'(bus.o_ball_x), 318);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Parameters (name, default, meaning): HRES 640, visible width px; VRES 480, visible height px; PAD_H 64, paddle height; PAD_W 8, paddle width; BALL 8, ball edge length; P1_X 16, left paddle x; P2_X 616, right paddle x; PAD_STEP 4, px per encoder step; BALL_V 2, ball px/frame per axis; SERVE_FRAMES 60, serve delay; WIN_SCORE 9, winning score.
REQ-002 Ports (name, direction, width, meaning):
- CLOCK_25 in 1: pixel clock, sole clock.
- rst_n in 1: reset, asynchronous, active-low.
- i_vblank in 1: vertical blank from the timing stage, asynchronous to CLOCK_25.
- player_1_a, player_1_b in 1 each: player 1 quadrature encoder.
- player_1_switch in 1: player 1 button, active-high.
- player_2_a, player_2_b, player_2_switch in 1 each: same for player 2.
- o_pad1_y, o_pad2_y out 10: paddle top y.
- o_ball_x, o_ball_y out 10: ball top-left corner.
- o_score1, o_score2 out 4: scores.
- o_state out 2: IDLE=0, SERVE=1, PLAY=2, OVER=3.
REQ-003 Position outputs SHALL feed the downstream image generator, which compares them against the current pixel x/y.

Function
REQ-004 Every asynchronous input SHALL pass through a 2-flop synchronizer before any use.
REQ-005 Frame tick SHALL be a one-cycle pulse on the rising edge of synchronized i_vblank (third flop holds the previous value); all ball, score, state and output updates occur only on the edge where tick=1.
REQ-006 Quadrature decode per player:
- Valid Gray transitions 00->01->11->10->00 = +1 (down); the reverse = -1.
- Double-bit change or no change = ignored.
REQ-007 Live paddle register SHALL move PAD_STEP per valid step in every state, saturating to [0, VRES-PAD_H]; no wrap.
REQ-008 o_pad*_y SHALL be latched from the live paddle registers on the tick, so no paddle change is visible mid-frame.
REQ-009 Button press = synchronized rising edge; held buttons do not repeat.
REQ-010 State machine:
- IDLE -> SERVE on either press (both in the same cycle = one start).
- SERVE counts SERVE_FRAMES ticks, ball held at centre, then -> PLAY.
- PLAY -> SERVE on a miss, or -> OVER when the scorer reaches WIN_SCORE.
- OVER -> SERVE on any press: scores cleared, serve direction +x.
REQ-011 Ball centre SHALL be (HRES-BALL)/2, (VRES-BALL)/2 = (316,236); velocity sign flags dx, dy; magnitude BALL_V.
REQ-012 PLAY per tick, using 11-bit signed next values nx = x±BALL_V and ny = y±BALL_V:
- Wall: ny<=0 -> y=0, dy=+. ny>=VRES-BALL -> y=VRES-BALL, dy=-.
- Left paddle: dx=- and nx<=P1_X+PAD_W and nx+BALL>P1_X and vertical overlap (y+BALL>pad1 and y<pad1+PAD_H) -> x=P1_X+PAD_W, dx=+.
- Right paddle: mirrored at P2_X -> x=P2_X-BALL, dx=-.
- Miss: nx<=0 -> score2+1. nx>=HRES-BALL -> score1+1. Then ball to centre, dx toward the losing player, dy kept.
- Priority: paddle > miss; walls are evaluated independently on y.
REQ-013 Vertical overlap SHALL use the live paddle position at the tick.
REQ-014 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-015 Pulse widths SHALL be insensitive to i_vblank pulse width and to encoder activity coinciding with a tick; both are processed in the same cycle.

Reset
REQ-016 On rst_n=0, immediately and asynchronously:
- State = IDLE; scores = 0.
- Ball = (316,236); dx=+, dy=+.
- Paddles and o_pad*_y = (VRES-PAD_H)/2 = 208.
- Synchronizers, serve counter and edge detectors cleared.
REQ-017 Reset assertion mid-PLAY or mid-SERVE SHALL abort to the REQ-016 values with no partial update; release is synchronous to CLOCK_25.

Verification
REQ-018 Scenarios:
- Reset then 5 ticks with no input -> state 0, ball (316,236), pads 208, scores 0.
- Press player_1_switch, 60 ticks -> state 2 on the tick after the 60th; next tick ball (318,238).
- 60 valid down-steps on player 2 -> pad2 live 416 (saturated, no wrap); o_pad2_y 416 only after the next tick.
- Ball at x=26, dx=-, pad1 overlapping -> x=24, dx=+; pad1 moved away, ball reaching x<=0 -> score2=1, state 1, ball centred, dx=-.
- score1=8 plus a player-1 point -> score1=9, state 3; press player_2_switch -> scores 0, state 1.
- rst_n low mid-PLAY -> all outputs match REQ-016 within the same cycle; a double-bit encoder change moves no paddle.
